// File: rtl/atr_pkg.sv
// ============================================================================
// atr_pkg: shared sequencer state codes and register-map offsets for the ATR
// bank controller.  Revision: 1.0
// ============================================================================
`default_nettype none

package atr_pkg;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] TX_DELAY = 2'd1;
    localparam logic [1:0] TX_ON    = 2'd2;
    localparam logic [1:0] RX_DELAY = 2'd3;

    localparam int OFF_CTL     = 0;
    localparam int OFF_TXD     = 1;
    localparam int OFF_RXD     = 2;
    localparam int OFF_BANK0   = 3;
    localparam int BANK_STRIDE = 4;
    localparam int OFF_IO      = 0;
    localparam int OFF_MASK    = 1;
    localparam int OFF_TXVAL   = 2;
    localparam int OFF_RXVAL   = 3;

    // 8-bit result so BASE_ADDR + window cannot alias back onto low addresses.
    function automatic logic [7:0] reg_addr(input logic [6:0] base, input int off);
        return 8'(int'(base) + off);
    endfunction

    function automatic logic [7:0] bank_addr(input logic [6:0] base, input int bank,
                                             input int off);
        return reg_addr(base, OFF_BANK0 + BANK_STRIDE * bank + off);
    endfunction

endpackage

`default_nettype wire

// File: rtl/atr_bank_ctrl_if.sv
// ============================================================================
// atr_bank_ctrl_if: serial settings bus (address, data, write strobe).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface atr_bank_ctrl_if;

    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;

    modport master (
        output serial_addr,
        output serial_data,
        output serial_strobe
    );

    modport slave (
        input serial_addr,
        input serial_data,
        input serial_strobe
    );

endinterface

`default_nettype wire

// File: rtl/atr_sequencer.sv
// ============================================================================
// atr_sequencer: TX/RX delay state machine driven by tx_empty.
// Revision: 1.0
// ============================================================================
`default_nettype none

module atr_sequencer
    import atr_pkg::*;
#(
    parameter int DELAY_WIDTH = 12
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   ena,
    input  wire logic                   tx_empty,
    input  wire logic [DELAY_WIDTH-1:0] tx_delay,
    input  wire logic [DELAY_WIDTH-1:0] rx_delay,
    output logic                        transmit_now,
    output logic [1:0]                  state
);

    logic [DELAY_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RX_IDLE;
            cnt          <= '0;
            transmit_now <= 1'b0;
        end else begin
            // Gated by ena so a disable drops transmit_now on the same edge
            // that returns the sequencer to RX_IDLE.
            transmit_now <= ena && ((state == TX_ON) || (state == RX_DELAY));

            if (!ena) begin
                state <= RX_IDLE;
            end else begin
                case (state)
                    RX_IDLE: begin
                        if (!tx_empty) begin
                            state <= TX_DELAY;
                            cnt   <= tx_delay;
                        end
                    end
                    TX_DELAY: begin
                        if (tx_empty) begin
                            state <= RX_IDLE;
                        end else if (cnt == '0) begin
                            state <= TX_ON;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    TX_ON: begin
                        if (tx_empty) begin
                            state <= RX_DELAY;
                            cnt   <= rx_delay;
                        end
                    end
                    RX_DELAY: begin
                        if (!tx_empty) begin
                            state <= TX_ON;
                        end else if (cnt == '0) begin
                            state <= RX_IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/atr_bank_ctrl.sv
// ============================================================================
// atr_bank_ctrl: ATR register window, per-bank masked I/O registers and
// output muxing around the TX/RX delay sequencer.  Revision: 1.0
// ============================================================================
`default_nettype none

module atr_bank_ctrl
    import atr_pkg::*;
#(
    parameter int         NUM_BANKS   = 4,
    parameter int         IO_WIDTH    = 16,
    parameter int         DELAY_WIDTH = 12,
    parameter logic [6:0] BASE_ADDR   = 7'd48
) (
    input  wire logic                          master_clk,
    input  wire logic                          reset_n,
    atr_bank_ctrl_if.slave                     sbus,
    input  wire logic                          tx_empty,
    output logic [NUM_BANKS*IO_WIDTH-1:0]      io_out,
    output logic                               transmit_now,
    output logic [1:0]                         atr_state
);

    logic                   atr_ena;
    logic [DELAY_WIDTH-1:0] tx_delay;
    logic [DELAY_WIDTH-1:0] rx_delay;
    logic [7:0]             addr;

    assign addr = {1'b0, sbus.serial_addr};

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            atr_ena  <= 1'b0;
            tx_delay <= '0;
            rx_delay <= '0;
        end else if (sbus.serial_strobe) begin
            if (addr == reg_addr(BASE_ADDR, OFF_CTL))
                atr_ena <= sbus.serial_data[0];
            if (addr == reg_addr(BASE_ADDR, OFF_TXD))
                tx_delay <= sbus.serial_data[DELAY_WIDTH-1:0];
            if (addr == reg_addr(BASE_ADDR, OFF_RXD))
                rx_delay <= sbus.serial_data[DELAY_WIDTH-1:0];
        end
    end

    atr_sequencer #(
        .DELAY_WIDTH (DELAY_WIDTH)
    ) u_seq (
        .clk          (master_clk),
        .rst_n        (reset_n),
        .ena          (atr_ena),
        .tx_empty     (tx_empty),
        .tx_delay     (tx_delay),
        .rx_delay     (rx_delay),
        .transmit_now (transmit_now),
        .state        (atr_state)
    );

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic [IO_WIDTH-1:0] io_reg;
            logic [IO_WIDTH-1:0] mask;
            logic [IO_WIDTH-1:0] txval;
            logic [IO_WIDTH-1:0] rxval;
            logic [IO_WIDTH-1:0] wmask;
            logic [IO_WIDTH-1:0] sel;
            logic [IO_WIDTH-1:0] m;
            logic [IO_WIDTH-1:0] bank_out;

            // Upper half of the data word selects which bits the lower half updates.
            assign wmask = sbus.serial_data[16 +: IO_WIDTH];

            always_ff @(posedge master_clk or negedge reset_n) begin
                if (!reset_n) begin
                    io_reg <= '0;
                    mask   <= '0;
                    txval  <= '0;
                    rxval  <= '0;
                end else if (sbus.serial_strobe) begin
                    if (addr == bank_addr(BASE_ADDR, b, OFF_IO))
                        io_reg <= (wmask & sbus.serial_data[IO_WIDTH-1:0]) | (~wmask & io_reg);
                    if (addr == bank_addr(BASE_ADDR, b, OFF_MASK))
                        mask <= sbus.serial_data[IO_WIDTH-1:0];
                    if (addr == bank_addr(BASE_ADDR, b, OFF_TXVAL))
                        txval <= sbus.serial_data[IO_WIDTH-1:0];
                    if (addr == bank_addr(BASE_ADDR, b, OFF_RXVAL))
                        rxval <= sbus.serial_data[IO_WIDTH-1:0];
                end
            end

            assign sel = transmit_now ? txval : rxval;
            assign m   = {IO_WIDTH{atr_ena}} & mask;

            always_ff @(posedge master_clk or negedge reset_n) begin
                if (!reset_n)
                    bank_out <= '0;
                else
                    bank_out <= (m & sel) | (~m & io_reg);
            end

            assign io_out[b*IO_WIDTH +: IO_WIDTH] = bank_out;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_atr_bank_ctrl.sv
// ============================================================================
// tb_atr_bank_ctrl: directed self-checking bench for atr_bank_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_atr_bank_ctrl;

    localparam int BASE = 48;

    logic        master_clk;
    logic        reset_n;
    logic        tx_empty;
    logic [63:0] io_out;
    logic        transmit_now;
    logic [1:0]  atr_state;

    int n_pass  = 0;
    int n_total = 0;

    atr_bank_ctrl_if sbus ();

    atr_bank_ctrl dut (
        .master_clk   (master_clk),
        .reset_n      (reset_n),
        .sbus         (sbus),
        .tx_empty     (tx_empty),
        .io_out       (io_out),
        .transmit_now (transmit_now),
        .atr_state    (atr_state)
    );

    initial master_clk = 1'b0;
    always #5 master_clk = ~master_clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge master_clk);
    endtask

    // Write lands on the posedge between the two negedges.
    task automatic wr(input int off, input logic [31:0] data);
        sbus.serial_addr   = 7'(BASE + off);
        sbus.serial_data   = data;
        sbus.serial_strobe = 1'b1;
        @(negedge master_clk);
        sbus.serial_strobe = 1'b0;
    endtask

    initial begin
        reset_n            = 1'b0;
        tx_empty           = 1'b1;
        sbus.serial_addr   = '0;
        sbus.serial_data   = '0;
        sbus.serial_strobe = 1'b0;
        tick(2);
        chk("rst_io_out", io_out, 64'h0);
        chk("rst_tx_now", {63'h0, transmit_now}, 64'h0);
        chk("rst_state", {62'h0, atr_state}, 64'h0);
        reset_n = 1'b1;
        tick(1);

        // Basic TX/RX cycle with TX_DELAY=3, RX_DELAY=2 on bank 0.
        wr(0, 32'h1);
        wr(1, 32'd3);
        wr(2, 32'd2);
        wr(4, 32'h00FF);
        wr(5, 32'h00A5);
        wr(6, 32'h005A);
        wr(3, 32'hFFFF_1234);
        tick(1);
        chk("idle_io_out", io_out, 64'h0000_0000_0000_125A);

        tx_empty = 1'b0;
        tick(1);
        chk("k_state_txdelay", {62'h0, atr_state}, 64'd1);
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            chk("txdelay_tx_now_low", {63'h0, transmit_now}, 64'h0);
        end
        chk("k4_state_txon", {62'h0, atr_state}, 64'd2);
        tick(1);
        chk("k5_tx_now_high", {63'h0, transmit_now}, 64'h1);
        chk("k5_io_still_rx", {48'h0, io_out[15:0]}, 64'h125A);
        tick(1);
        chk("k6_io_tx", {48'h0, io_out[15:0]}, 64'h12A5);

        tx_empty = 1'b1;
        tick(1);
        chk("m_state_rxdelay", {62'h0, atr_state}, 64'd3);
        chk("m_tx_now_held", {63'h0, transmit_now}, 64'h1);
        tick(3);
        chk("m3_state_idle", {62'h0, atr_state}, 64'd0);
        chk("m3_tx_now_held", {63'h0, transmit_now}, 64'h1);
        tick(1);
        chk("m4_tx_now_low", {63'h0, transmit_now}, 64'h0);
        chk("m4_io_tx", {48'h0, io_out[15:0]}, 64'h12A5);
        tick(1);
        chk("m5_io_rx", {48'h0, io_out[15:0]}, 64'h125A);

        // Aborted transmission: tx_empty low only 4 cycles with TX_DELAY=10.
        wr(1, 32'd10);
        tx_empty = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("abort_state_txdelay", {62'h0, atr_state}, 64'd1);
            chk("abort_tx_now_low", {63'h0, transmit_now}, 64'h0);
        end
        tx_empty = 1'b1;
        tick(1);
        chk("abort_state_idle", {62'h0, atr_state}, 64'd0);
        tick(2);
        chk("abort_tx_now_never", {63'h0, transmit_now}, 64'h0);

        // Re-key from RX_DELAY at count 15, TX_DELAY=0.
        wr(1, 32'd0);
        wr(2, 32'd20);
        tx_empty = 1'b0;
        tick(3);
        chk("d0_state_txon", {62'h0, atr_state}, 64'd2);
        chk("d0_tx_now", {63'h0, transmit_now}, 64'h1);
        tx_empty = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("rekey_state_rxdelay", {62'h0, atr_state}, 64'd3);
        end
        tx_empty = 1'b0;
        tick(1);
        chk("rekey_state_txon", {62'h0, atr_state}, 64'd2);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rekey_tx_now_held", {63'h0, transmit_now}, 64'h1);
        end

        // Masked write on bank 1 and out-of-window writes.
        wr(7, 32'h00FF_00FF);
        wr(7, 32'h0F00_0A00);
        tick(1);
        chk("bank1_masked_write", {48'h0, io_out[31:16]}, 64'h0AFF);
        wr(3 + 4 * 4, 32'hFFFF_FFFF);
        wr(-1, 32'hFFFF_FFFF);
        tick(2);
        chk("out_of_window", io_out, 64'h0000_0000_0AFF_12A5);
        chk("out_of_window_state", {62'h0, atr_state}, 64'd2);

        // atr_ena cleared while in TX_ON.
        wr(0, 32'h0);
        tick(1);
        chk("dis_state_idle", {62'h0, atr_state}, 64'd0);
        chk("dis_tx_now_low", {63'h0, transmit_now}, 64'h0);
        chk("dis_io_is_ioreg", io_out, 64'h0000_0000_0AFF_1234);
        tick(2);
        chk("dis_stays_idle", {62'h0, atr_state}, 64'd0);

        // Asynchronous reset in the middle of TX_ON.
        wr(0, 32'h1);
        tick(3);
        chk("pre_rst_state_txon", {62'h0, atr_state}, 64'd2);
        chk("pre_rst_tx_now", {63'h0, transmit_now}, 64'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_io_out", io_out, 64'h0);
        chk("async_rst_tx_now", {63'h0, transmit_now}, 64'h0);
        chk("async_rst_state", {62'h0, atr_state}, 64'd0);
        tick(1);
        reset_n = 1'b1;
        tick(2);
        chk("post_rst_idle_ena_clear", {62'h0, atr_state}, 64'd0);
        wr(0, 32'h1);
        tick(3);
        chk("post_rst_txd_zero", {63'h0, transmit_now}, 64'h1);
        chk("post_rst_regs_zero", io_out, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
